// File: rtl/trng_vnc_packer.sv
// trng_vnc_packer
//   Corrects the synchronised raw TRNG bit stream. The corrector is selected
//   by mode: von Neumann, XOR-pair or bypass. It packs the corrected bits
//   LSB-first into OUT_W-bit words and delivers them over valid/ready. It also
//   runs a repetition-count health test on the raw stream.
//
// Ports
//   rng_clk         clock
//   rst_n           asynchronous active-low reset
//   rst_trng_logic  synchronous clear of all datapath state (priority after rst_n)
//   rnd_src_en      source enable; raw bits ignored and half pair dropped when low
//   mode[1:0]       00 von Neumann, 01 bypass, 10 XOR-pair, 11 as 00
//   in_valid        raw bit strobe
//   in_data         raw bit
//   out_ready       consumer accepts word
//   out_valid       word available
//   out_data        packed word, first emitted bit in bit 0
//   rct_err         one-cycle repetition-count error pulse
//   ovf_err         sticky: a corrected bit was dropped
module trng_vnc_packer #(
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned RCT_CUTOFF = 32,
   parameter int unsigned RUN_W      = 8
) (
   input  logic             rng_clk,
   input  logic             rst_n,
   input  logic             rst_trng_logic,
   input  logic             rnd_src_en,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic             in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             rct_err,
   output logic             ovf_err
);

   localparam int unsigned FILL_W = $clog2(OUT_W + 1);

   typedef enum logic [1:0] {
      MODE_VN  = 2'b00,
      MODE_BYP = 2'b01,
      MODE_XOR = 2'b10,
      MODE_RSV = 2'b11
   } mode_t;

   typedef enum logic {
      PAIR_EMPTY = 1'b0,
      PAIR_HALF  = 1'b1
   } pair_t;

   pair_t             pair_q, pair_d;
   logic              first_q;
   logic [OUT_W-1:0]  shifter_q, shifter_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              prev_q;
   logic [RUN_W-1:0]  run_q, run_d, run_inc;
   logic              accept, is_byp, is_xor;
   logic              emit, emit_bit;
   logic              full, transfer, drop;
   logic              rct_hit;

   assign accept = in_valid && rnd_src_en && !rst_trng_logic;
   assign is_byp = (mode_t'(mode) == MODE_BYP);
   assign is_xor = (mode_t'(mode) == MODE_XOR);

   // Pair stage: decides whether this accepted bit produces a corrected bit.
   always_comb begin
      pair_d   = pair_q;
      emit     = 1'b0;
      emit_bit = in_data;
      if (!rnd_src_en) begin
         pair_d = PAIR_EMPTY;
      end else if (accept) begin
         if (is_byp) begin
            emit   = 1'b1;
            pair_d = PAIR_EMPTY;
         end else begin
            case (pair_q)
               PAIR_EMPTY: pair_d = PAIR_HALF;
               PAIR_HALF: begin
                  pair_d = PAIR_EMPTY;
                  if (is_xor) begin
                     emit     = 1'b1;
                     emit_bit = first_q ^ in_data;
                  end else begin
                     emit     = (first_q != in_data);
                     emit_bit = first_q;
                  end
               end
               default: pair_d = PAIR_EMPTY;
            endcase
         end
      end
   end

   assign full     = (fill_q == FILL_W'(OUT_W));
   assign transfer = full && (!out_valid || out_ready);

   // Shifter: a bit emitted on a transfer edge starts the next word at bit 0.
   always_comb begin
      shifter_d = shifter_q;
      fill_d    = fill_q;
      drop      = 1'b0;
      if (transfer) begin
         shifter_d = '0;
         fill_d    = '0;
         if (emit) begin
            shifter_d[0] = emit_bit;
            fill_d       = FILL_W'(1);
         end
      end else if (emit) begin
         if (full) begin
            drop = 1'b1;
         end else begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
               if (fill_q == FILL_W'(i)) shifter_d[i] = emit_bit;
            end
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   // Repetition count on raw bits; a saturated counter can never re-pulse.
   assign run_inc = (run_q == '1) ? run_q : run_q + RUN_W'(1);
   assign run_d   = (in_data == prev_q && run_q != '0) ? run_inc : RUN_W'(1);
   assign rct_hit = accept && (run_d == RUN_W'(RCT_CUTOFF)) && (run_q != RUN_W'(RCT_CUTOFF));

   always_ff @(posedge rng_clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_q    <= PAIR_EMPTY;
         first_q   <= 1'b0;
         shifter_q <= '0;
         fill_q    <= '0;
         prev_q    <= 1'b0;
         run_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         rct_err   <= 1'b0;
         ovf_err   <= 1'b0;
      end else if (rst_trng_logic) begin
         pair_q    <= PAIR_EMPTY;
         first_q   <= 1'b0;
         shifter_q <= '0;
         fill_q    <= '0;
         prev_q    <= 1'b0;
         run_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         rct_err   <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         pair_q    <= pair_d;
         shifter_q <= shifter_d;
         fill_q    <= fill_d;
         rct_err   <= rct_hit;
         if (accept && !is_byp && pair_q == PAIR_EMPTY) first_q <= in_data;
         if (accept) begin
            prev_q <= in_data;
            run_q  <= run_d;
         end
         if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= shifter_q;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop) ovf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_trng_vnc_packer.sv
module tb_trng_vnc_packer;

   logic       rng_clk = 1'b0;
   logic       rst_n;
   logic       rst_trng_logic;
   logic       rnd_src_en;
   logic [1:0] mode;
   logic       in_valid;
   logic       in_data;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       rct_err;
   logic       ovf_err;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb[$];

   always #5 rng_clk = ~rng_clk;

   trng_vnc_packer #(.OUT_W(8), .RCT_CUTOFF(32), .RUN_W(8)) dut (
      .rng_clk(rng_clk), .rst_n(rst_n), .rst_trng_logic(rst_trng_logic),
      .rnd_src_en(rnd_src_en), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .rct_err(rct_err), .ovf_err(ovf_err)
   );

   // Scoreboard: each word about to be consumed is compared with the oldest expected word.
   always @(negedge rng_clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL word_unexpected: got %h, none expected", out_data);
         end else begin
            logic [7:0] exp_w;
            exp_w = sb.pop_front();
            if (out_data !== exp_w) begin
               errors++;
               $display("FAIL word: got %h expected %h", out_data, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge rng_clk); #1;
   endtask

   task automatic send_bit(input logic b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word_lsb(input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(w[i]);
   endtask

   task automatic pulse_clear();
      rst_trng_logic = 1'b1;
      tick();
      rst_trng_logic = 1'b0;
   endtask

   task automatic set_mode(input logic [1:0] m);
      rnd_src_en = 1'b0;
      tick();
      mode = m;
      tick();
      rnd_src_en = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL %s_drain: %0d words pending, out_valid=%b, required 0", name, sb.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_trng_logic = 1'b0; rnd_src_en = 1'b0; mode = 2'b00;
      in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge rng_clk);
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h required 00", out_data); end
      if (rct_err !== 1'b0) begin errors++; $display("FAIL reset_rct_err: got %b required 0", rct_err); end
      if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err: got %b required 0", ovf_err); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_vn();
      set_mode(2'b00);
      out_ready = 1'b1;
      sb.push_back(8'hAA);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); end
         else            begin send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); end
      end
      wait_drain("vn");
      checks++;
      if (ovf_err !== 1'b0) begin errors++; $display("FAIL vn_ovf: got %b required 0", ovf_err); end
   endtask

   task automatic test_bypass();
      logic [7:0] w;
      set_mode(2'b01);
      out_ready = 1'b1;
      sb.push_back(8'h01);
      sb.push_back(8'h0F);
      w = 8'h01;
      send_word_lsb(w);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL byp_valid_early: got %b required 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid_rise: got %b required 1", out_valid); end
      w = 8'h0F;
      send_word_lsb(w);
      wait_drain("bypass");
   endtask

   task automatic test_xor();
      logic [15:0] seq;
      set_mode(2'b10);
      out_ready = 1'b1;
      seq = 16'b11_01_10_00_01_01_00_10;
      sb.push_back(8'hB6);
      for (int i = 15; i >= 0; i--) send_bit(seq[i]);
      wait_drain("xor");
   endtask

   task automatic test_overflow();
      set_mode(2'b01);
      pulse_clear();
      out_ready = 1'b0;
      sb.push_back(8'h5C);
      sb.push_back(8'hE3);
      send_word_lsb(8'h5C);
      send_word_lsb(8'hE3);
      send_bit(1'b1);
      checks += 3;
      if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf_err); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b required 1", out_valid); end
      if (out_data !== 8'h5C) begin errors++; $display("FAIL ovf_hold: got %h required 5c", out_data); end
      repeat (3) tick();
      checks++;
      if (out_data !== 8'h5C) begin errors++; $display("FAIL ovf_stable: got %h required 5c", out_data); end
      out_ready = 1'b1;
      wait_drain("overflow");
      checks++;
      if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", ovf_err); end
      pulse_clear();
      checks++;
      if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", ovf_err); end
   endtask

   task automatic test_rct();
      int pulses;
      logic exp_r;
      set_mode(2'b01);
      out_ready = 1'b1;
      pulse_clear();
      pulses = 0;
      repeat (5) sb.push_back(8'hFF);
      for (int i = 1; i <= 40; i++) begin
         send_bit(1'b1);
         exp_r = (i == 32);
         if (rct_err === 1'b1) pulses++;
         checks++;
         if (rct_err !== exp_r) begin errors++; $display("FAIL rct_run40 bit %0d: got %b required %b", i, rct_err, exp_r); end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL rct_pulses: got %0d required 1", pulses); end
      wait_drain("rct40");
      pulse_clear();
      sb.push_back(8'hFF); sb.push_back(8'hFF); sb.push_back(8'hFF); sb.push_back(8'h7F);
      pulses = 0;
      for (int i = 1; i <= 32; i++) begin
         send_bit(i != 32);
         if (rct_err === 1'b1) pulses++;
      end
      tick();
      if (rct_err === 1'b1) pulses++;
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL rct_31: got %0d pulses required 0", pulses); end
      wait_drain("rct31");
   endtask

   task automatic test_flush();
      set_mode(2'b01);
      out_ready = 1'b1;
      pulse_clear();
      repeat (5) send_bit(1'b1);
      pulse_clear();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", out_valid); end
      sb.push_back(8'h96);
      send_word_lsb(8'h96);
      wait_drain("flush_byp");
      set_mode(2'b00);
      send_bit(1'b1);
      pulse_clear();
      sb.push_back(8'h0F);
      repeat (4) begin send_bit(1'b1); send_bit(1'b0); end
      repeat (4) begin send_bit(1'b0); send_bit(1'b1); end
      wait_drain("flush_vn");
   endtask

   task automatic test_src_en();
      logic [7:0] w;
      set_mode(2'b00);
      out_ready = 1'b1;
      send_bit(1'b0);
      rnd_src_en = 1'b0;
      tick();
      rnd_src_en = 1'b1;
      w = 8'hA5;
      sb.push_back(w);
      for (int i = 0; i < 8; i++) begin
         if (w[i]) begin send_bit(1'b1); send_bit(1'b0); end
         else      begin send_bit(1'b0); send_bit(1'b1); end
      end
      wait_drain("src_en_half");
      // pending word must drain while the source is disabled
      set_mode(2'b01);
      out_ready = 1'b0;
      sb.push_back(8'h3C);
      send_word_lsb(8'h3C);
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL src_en_pending: got %b required 1", out_valid); end
      rnd_src_en = 1'b0;
      in_valid = 1'b1;
      in_data = 1'b1;
      repeat (10) tick();
      out_ready = 1'b1;
      repeat (10) tick();
      in_valid = 1'b0;
      wait_drain("src_en_off");
      rnd_src_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      set_mode(2'b01);
      out_ready = 1'b1;
      pulse_clear();
      for (int k = 0; k < 6; k++) begin
         logic [7:0] w;
         w = 8'(($urandom_range(0, 255) & 8'hFE) | (k & 1));
         sb.push_back(w);
         send_word_lsb(w);
      end
      wait_drain("b2b");
      checks++;
      if (ovf_err !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b required 0", ovf_err); end
   endtask

   initial begin
      test_reset();
      test_vn();
      test_bypass();
      test_xor();
      test_overflow();
      test_rct();
      test_flush();
      test_src_en();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trng_vnc_packer.md
# trng_vnc_packer

Parametrised successor to the TRNG balance filter. It takes the synchronised raw entropy bit stream and applies a selectable corrector: von Neumann, XOR-pair or bypass. It runs a repetition-count health test on the raw stream and packs corrected bits LSB-first into OUT_W-bit words, delivered over a valid/ready handshake. It sits between the sampling/synchroniser stage and the entropy collection logic in the rng_clk domain.

## Interface
- OUT_W, 8, output word width in bits, 1..32
- RCT_CUTOFF, 32, raw run length that flags a repetition error, 2..255
- RUN_W, 8, width of the run-length counter; 2^RUN_W-1 >= RCT_CUTOFF
- rng_clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- rst_trng_logic  input  1  synchronous clear of all datapath state
- rnd_src_en  input  1  source enable; when low, input is ignored
- mode  input  2  corrector mode: 00 von Neumann, 01 bypass, 10 XOR-pair, 11 treated as 00
- in_valid  input  1  raw bit strobe
- in_data  input  1  raw bit
- out_ready  input  1  consumer accepts word
- out_valid  output  1  word available
- out_data  output  OUT_W  packed word, first emitted bit in bit 0
- rct_err  output  1  one-cycle repetition-count error pulse
- ovf_err  output  1  sticky overflow, a corrected bit was dropped

## Operation
- **Reset values:** all outputs are 0. Internal state resets as follows: pair flag 0, shifter 0, fill count 0, prev bit 0, run length 0.
- **Accepting a raw bit:** a raw bit is accepted when in_valid && rnd_src_en && !rst_trng_logic.
- **Pair stage (modes 00/10):**
  - First accepted bit: store it as a, set have_first.
  - Second accepted bit b: clear have_first, then:
    - VN mode emits a if a!=b; pairs 00 and 11 emit nothing.
    - XOR mode emits a^b for every pair.
- **Bypass (01):** every accepted bit is emitted directly; the pair stage is unused and have_first is held at 0.
- **Shifter:** an emitted bit is written at position fill_cnt and fill_cnt increments. The shifter is full when fill_cnt==OUT_W.
- **Transfer:** on an edge where the shifter is full and (!out_valid || out_ready):
  - out_data <= shifter, out_valid <= 1, fill_cnt <= 0.
  - If a bit is emitted on the same edge, it lands at position 0 and fill_cnt <= 1.
- **Handshake:**
  - A word is consumed on an edge with out_valid && out_ready.
  - out_valid falls after consumption unless a transfer occurs on the same edge.
  - out_data is stable while out_valid && !out_ready.
- **Overflow:** if a bit is emitted while the shifter is full and no transfer occurs on that edge, the bit is dropped and ovf_err <= 1. ovf_err holds until rst_trng_logic or rst_n.
- **Repetition-count test (all modes, on raw accepted bits):**
  - run_len <= (in_data==prev_bit && run_len!=0) ? sat(run_len+1) : 1.
  - prev_bit <= in_data.
  - rct_err is registered. It pulses for one cycle after the edge on which run_len becomes exactly RCT_CUTOFF.
  - A continued run does not re-pulse; a new run must break and regrow.
- **rnd_src_en low:**
  - have_first clears.
  - Raw bits are ignored; run_len and prev_bit hold.
  - Shifter and output register are retained, so a pending word still drains.
- **rst_trng_logic (priority over all but rst_n):** clears have_first, shifter, fill_cnt, out_valid, out_data, run_len, prev_bit, rct_err and ovf_err.
- **Mode changes:** software changes mode only while rnd_src_en=0. mode is sampled at each accepted bit.

## Timing
- Raw bit to shifter: bit accepted at edge k, shifter updated at edge k.
- Word completion to out_valid: if the completing bit is written at edge k, out_valid is high after edge k+1. This requires the output register to be free or being drained at k+1.
- Throughput: one word per OUT_W emitted bits. A word is blocked only if the consumer stalls longer than one full shifter fill.
- rct_err latency: high the cycle after the edge accepting the RCT_CUTOFF-th identical bit.
- The fill_cnt width is clog2(OUT_W+1). Counter overflow is not possible.

## Test plan
- **VN mode, 16 pairs alternating 01,10, with 00/11 pairs interleaved, out_ready=1** -> exactly one word out_data=8'hAA; 00/11 pairs contribute nothing; ovf_err=0.
- **Bypass mode, bits 1,0,0,0,0,0,0,0 then 1,1,1,1,0,0,0,0** -> words 8'h01 then 8'h0F; out_valid rises the cycle after the edge following the 8th bit.
- **XOR mode, pairs 11,01,10,00,01,01,00,10** -> word 8'b1011_0110 (0xB6).
- **Bypass, out_ready=0, 17 bits fed** -> first word held stable; second word fills the shifter; 17th bit dropped with ovf_err=1. Then out_ready=1 -> 0x.. words delivered in order; ovf_err stays 1 until rst_trng_logic.
- **RCT_CUTOFF=32 with 40 consecutive 1s** -> a single rct_err pulse the cycle after the 32nd bit. 31 ones then a 0 -> no pulse.
- **Bypass, rst_trng_logic after 5 bits, and VN after a half pair** -> out_valid=0, and the next word needs 8 fresh bits. Toggling rnd_src_en mid-pair discards the stored half pair, while a pending out_valid word still completes its handshake.
